prco_lmem_arb: RTL
==================

// Module: prco_lmem_arb
// PURPOSE
//  Arbitrates the single local-memory port between instruction fetch (read-only)
//  and the load/store unit (read/write). Sits between the fetch/execute stages and
//  prco_lmem. One access in flight at a time; each requester gets req/ack/valid.
//  Access latency is set by parameter to match the memory's registered read.
// PARAMETERS
//  P_ADDR_W     16  address width of both requesters and the memory port
//  P_DATA_W     16  data width
//  P_MEM_LAT    1   cycles from q_mem_ce to valid i_mem_douta; legal 1..7
//  P_DATA_PRIO  0   1 = load/store always wins a tie; 0 = round-robin
// PORTS
//  i_clk        in   1         clock, rising edge
//  i_reset      in   1         asynchronous, active-low reset
//  i_if_req     in   1         fetch read request; hold until q_if_ack
//  i_if_addr    in   ADDR_W    fetch address
//  q_if_ack     out  1         1-cycle pulse: fetch request captured
//  q_if_valid   out  1         1-cycle pulse: q_if_data valid
//  q_if_data    out  DATA_W    fetched word; holds until next fetch completes
//  i_ls_req     in   1         load/store request; hold until q_ls_ack
//  i_ls_we      in   1         1 = store, 0 = load
//  i_ls_addr    in   ADDR_W    load/store address
//  i_ls_wdata   in   DATA_W    store data
//  q_ls_ack     out  1         1-cycle pulse: load/store request captured
//  q_ls_valid   out  1         1-cycle pulse: load data valid / store completed
//  q_ls_rdata   out  DATA_W    load data; not updated by stores
//  q_mem_ce     out  1         memory enable, exactly one cycle per access
//  q_mem_we     out  1         memory write enable; only with q_mem_ce
//  q_mem_addr   out  ADDR_W    memory address, held for the whole access
//  q_mem_dina   out  DATA_W    memory write data
//  i_mem_douta  in   DATA_W    memory read data
//  q_busy       out  1         1 while state != IDLE
// BEHAVIOUR
//  - Reset (i_reset=0): all outputs 0, state IDLE, latency counter 0.
//    Round-robin pointer = "LS last", so fetch wins the first tie.
//  - FSM: IDLE -> ACCESS -> IDLE. All outputs registered.
//  - IDLE, any req high at an edge: select winner, latch owner/we/addr/wdata.
//    Next cycle (C1): q_x_ack=1, q_mem_ce=1, q_mem_we=(owner LS && we), state ACCESS.
//  - Fetch owner: q_mem_we is always 0.
//  - ACCESS: 3-bit counter counts from 0 on C1. q_mem_ce/q_mem_we go low after C1.
//    q_mem_addr/q_mem_dina are held stable.
//  - Cycle C1+P_MEM_LAT: i_mem_douta is sampled at the end of the cycle.
//    Next cycle: q_x_valid=1, state IDLE.
//    Loads/fetches load q_x_data; stores leave q_ls_rdata unchanged.
//  - The completion cycle is IDLE and arbitrates again.
//    Back-to-back throughput: one access per P_MEM_LAT+2 cycles.
//  - Tie rules: P_DATA_PRIO=1 -> LS wins, so fetch may starve (accepted).
//    P_DATA_PRIO=0 -> grant goes to the requester not granted last.
//    Pointer updates on every grant, including uncontested ones.
//  - Requests arriving during ACCESS are not acked; requester holds req.
//    Inputs are free to change after ack.
//  - Exactly one of q_if_ack/q_ls_ack per access; never both in one cycle.
//    Same for the valid pulses.
//  - Reset mid-access: outputs clear immediately (async) and the access is dropped.
//    No ack/valid afterwards. A store whose q_mem_ce was already issued may have
//    committed.
//  - P_MEM_LAT outside 1..7: elaboration error.
// TESTING
//  1. P_MEM_LAT=1, mem[0x0005]=0x24AA; fetch req addr 0x0005 at C0.
//     -> C1: q_if_ack, q_mem_ce, addr 0x0005, we=0; C3: q_if_valid, q_if_data=0x24AA.
//  2. LS store 0x00AB <- 0xCAFE.
//     -> C1: q_mem_ce=q_mem_we=1, dina 0xCAFE; C3: q_ls_valid, q_ls_rdata unchanged.
//     Then load 0x00AB -> q_ls_rdata=0xCAFE.
//  3. Both reqs held for 4 grants after reset:
//     P_DATA_PRIO=0 -> IF,LS,IF,LS; P_DATA_PRIO=1 -> LS,LS,LS,LS.
//  4. P_MEM_LAT=3: fetch at C0 -> valid at C5 with the data driven in C4.
//     An LS req raised at C2 is acked at C6, not before; single q_mem_ce per access.
//  5. Reset pulse in C2 of an access: all outputs 0 during reset.
//     No valid after release; next fetch completes per test 1.
//  6. Fetch req held high continuously, LAT=1 -> q_if_ack every 3 cycles.
//     q_busy low only in the completion cycles.

Source files
------------

// File: rtl/prco_lmem_arb.sv
// Local-memory port arbiter: instruction fetch (read-only) vs. load/store (read/write).
// One access in flight; fixed read latency P_MEM_LAT; fixed or round-robin tie break.
module prco_lmem_arb #(
    parameter int unsigned P_ADDR_W    = 16,
    parameter int unsigned P_DATA_W    = 16,
    parameter int unsigned P_MEM_LAT   = 1,
    parameter int unsigned P_DATA_PRIO = 0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_if_req,
    input  logic [P_ADDR_W-1:0] i_if_addr,
    output logic                q_if_ack,
    output logic                q_if_valid,
    output logic [P_DATA_W-1:0] q_if_data,
    input  logic                i_ls_req,
    input  logic                i_ls_we,
    input  logic [P_ADDR_W-1:0] i_ls_addr,
    input  logic [P_DATA_W-1:0] i_ls_wdata,
    output logic                q_ls_ack,
    output logic                q_ls_valid,
    output logic [P_DATA_W-1:0] q_ls_rdata,
    output logic                q_mem_ce,
    output logic                q_mem_we,
    output logic [P_ADDR_W-1:0] q_mem_addr,
    output logic [P_DATA_W-1:0] q_mem_dina,
    input  logic [P_DATA_W-1:0] i_mem_douta,
    output logic                q_busy
);

    if (P_MEM_LAT < 1 || P_MEM_LAT > 7) begin : g_bad_lat
        $error("prco_lmem_arb: P_MEM_LAT must be in 1..7");
    end

    typedef enum logic {StIdle, StAccess} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       owner_ls;
    logic       owner_we;
    logic       last_ls;
    logic       grant_ls;

    // On a tie, load/store wins under fixed priority or when fetch was granted last.
    assign grant_ls = i_ls_req && (!i_if_req || (P_DATA_PRIO != 0) || !last_ls);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= StIdle;
            cnt        <= 3'd0;
            owner_ls   <= 1'b0;
            owner_we   <= 1'b0;
            last_ls    <= 1'b1;
            q_if_ack   <= 1'b0;
            q_if_valid <= 1'b0;
            q_if_data  <= '0;
            q_ls_ack   <= 1'b0;
            q_ls_valid <= 1'b0;
            q_ls_rdata <= '0;
            q_mem_ce   <= 1'b0;
            q_mem_we   <= 1'b0;
            q_mem_addr <= '0;
            q_mem_dina <= '0;
            q_busy     <= 1'b0;
        end else begin
            q_if_ack   <= 1'b0;
            q_ls_ack   <= 1'b0;
            q_if_valid <= 1'b0;
            q_ls_valid <= 1'b0;
            q_mem_ce   <= 1'b0;
            q_mem_we   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (i_if_req || i_ls_req) begin
                        owner_ls   <= grant_ls;
                        owner_we   <= grant_ls && i_ls_we;
                        last_ls    <= grant_ls;
                        q_if_ack   <= !grant_ls;
                        q_ls_ack   <= grant_ls;
                        q_mem_ce   <= 1'b1;
                        q_mem_we   <= grant_ls && i_ls_we;
                        q_mem_addr <= grant_ls ? i_ls_addr : i_if_addr;
                        q_mem_dina <= grant_ls ? i_ls_wdata : '0;
                        cnt        <= 3'd0;
                        q_busy     <= 1'b1;
                        state      <= StAccess;
                    end
                end
                StAccess: begin
                    if (cnt == 3'(P_MEM_LAT)) begin
                        state  <= StIdle;
                        q_busy <= 1'b0;
                        if (owner_ls) begin
                            q_ls_valid <= 1'b1;
                            if (!owner_we) begin
                                q_ls_rdata <= i_mem_douta;
                            end
                        end else begin
                            q_if_valid <= 1'b1;
                            q_if_data  <= i_mem_douta;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
